key_debounce_n: RTL and testbench

KEY_DEBOUNCE_N -- requirements
Module: key_debounce_n

---
 rtl/key_pkg.sv | 17 +
 rtl/key_debounce_n_if.sv | 21 ++
 rtl/key_chan.sv | 119 +++++++++++
 rtl/key_debounce_n.sv | 65 ++++++
 tb/tb_key_debounce_n.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/key_pkg.sv
// Shared types and width helpers for the key debouncer slice.
package key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_HELD
  } key_state_e;

  // STABLE_CNT is limited to 15, so a 4-bit difference counter always suffices.
  localparam int unsigned DIFF_W = 4;

  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_debounce_n_if.sv
// Key bus: raw active-low keys in, debounced level and event pulses out.
interface key_debounce_n_if #(
  parameter int unsigned N_KEYS = 3
);
  logic [N_KEYS-1:0] key_in;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] press_pulse;
  logic [N_KEYS-1:0] release_pulse;
  logic [N_KEYS-1:0] long_pulse;
  logic [N_KEYS-1:0] repeat_pulse;

  modport master (
    output key_in,
    input  key_level, press_pulse, release_pulse, long_pulse, repeat_pulse
  );

  modport slave (
    input  key_in,
    output key_level, press_pulse, release_pulse, long_pulse, repeat_pulse
  );
endinterface

// File: rtl/key_chan.sv
// One key channel: 2-FF synchronizer, tick-sampled debounce, press/hold FSM.
module key_chan
  import key_pkg::*;
#(
  parameter int unsigned STABLE_CNT   = 3,
  parameter int unsigned LONG_TICKS   = 100,
  parameter int unsigned REPEAT_TICKS = 20,
  parameter int unsigned REPEAT_EN    = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic key_in,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int unsigned HOLD_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int unsigned HOLD_W   = cnt_w(HOLD_MAX);
  localparam logic [DIFF_W-1:0] STABLE_M1 = DIFF_W'(STABLE_CNT - 1);
  localparam logic [HOLD_W-1:0] LONG_M1   = HOLD_W'(LONG_TICKS - 1);
  localparam logic [HOLD_W-1:0] REP_M1    = HOLD_W'(REPEAT_TICKS - 1);

  logic [1:0]        sync;
  logic [DIFF_W-1:0] diff_cnt;
  logic              level_d;
  logic              raw_press;
  logic              rise;
  logic              fall;
  key_state_e        state;
  logic [HOLD_W-1:0] hold_cnt;

  assign raw_press = ~sync[1];
  assign rise      = key_level & ~level_d;
  assign fall      = ~key_level & level_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync      <= 2'b11;
      diff_cnt  <= '0;
      key_level <= 1'b0;
      level_d   <= 1'b0;
    end else begin
      sync    <= {sync[0], key_in};
      level_d <= key_level;
      if (tick) begin
        if (raw_press != key_level) begin
          if (diff_cnt == STABLE_M1) begin
            key_level <= ~key_level;
            diff_cnt  <= '0;
          end else begin
            diff_cnt <= diff_cnt + 1'b1;
          end
        end else begin
          diff_cnt <= '0;
        end
      end
    end
  end

  // Edges of key_level drive both the pulses and the FSM one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      hold_cnt      <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      press_pulse   <= rise;
      release_pulse <= fall;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      if (fall) begin
        state    <= ST_IDLE;
        hold_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rise) begin
              state    <= ST_PRESSED;
              hold_cnt <= '0;
            end
          end
          ST_PRESSED: begin
            if (tick) begin
              if (hold_cnt == LONG_M1) begin
                long_pulse <= 1'b1;
                state      <= ST_HELD;
                hold_cnt   <= '0;
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
          end
          ST_HELD: begin
            if (REPEAT_EN != 0 && tick) begin
              if (hold_cnt == REP_M1) begin
                repeat_pulse <= 1'b1;
                hold_cnt     <= '0;
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
          end
          default: begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/key_debounce_n.sv
// Multi-key debouncer: one shared sample-tick divider feeding N_KEYS channels.
module key_debounce_n
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS       = 3,
  parameter int unsigned TICK_DIV     = 500000,
  parameter int unsigned STABLE_CNT   = 3,
  parameter int unsigned LONG_TICKS   = 100,
  parameter int unsigned REPEAT_TICKS = 20,
  parameter int unsigned REPEAT_EN    = 1
) (
  input logic             clk,
  input logic             rst,
  key_debounce_n_if.slave bus
);

  localparam int unsigned TICK_W = cnt_w(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic [N_KEYS-1:0] level_v;
  logic [N_KEYS-1:0] press_v;
  logic [N_KEYS-1:0] release_v;
  logic [N_KEYS-1:0] long_v;
  logic [N_KEYS-1:0] repeat_v;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
    key_chan #(
      .STABLE_CNT  (STABLE_CNT),
      .LONG_TICKS  (LONG_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS),
      .REPEAT_EN   (REPEAT_EN)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .tick         (tick),
      .key_in       (bus.key_in[g]),
      .key_level    (level_v[g]),
      .press_pulse  (press_v[g]),
      .release_pulse(release_v[g]),
      .long_pulse   (long_v[g]),
      .repeat_pulse (repeat_v[g])
    );
  end

  assign bus.key_level     = level_v;
  assign bus.press_pulse   = press_v;
  assign bus.release_pulse = release_v;
  assign bus.long_pulse    = long_v;
  assign bus.repeat_pulse  = repeat_v;

endmodule

// File: tb/tb_key_debounce_n.sv
// Bench for key_debounce_n: event-level reference model, per-cycle compare, directed and random keys.
module tb_key_debounce_n;

  localparam int unsigned NK = 3;
  localparam int unsigned TD = 4;
  localparam int unsigned SC = 3;
  localparam int unsigned LT = 8;
  localparam int unsigned RT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] keys = '1;

  always #5 clk = ~clk;

  key_debounce_n_if #(.N_KEYS(NK)) bus_a ();
  key_debounce_n_if #(.N_KEYS(NK)) bus_b ();

  assign bus_a.key_in = keys;
  assign bus_b.key_in = keys;

  key_debounce_n #(
    .N_KEYS(NK), .TICK_DIV(TD), .STABLE_CNT(SC),
    .LONG_TICKS(LT), .REPEAT_TICKS(RT), .REPEAT_EN(1)
  ) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));

  key_debounce_n #(
    .N_KEYS(NK), .TICK_DIV(TD), .STABLE_CNT(SC),
    .LONG_TICKS(LT), .REPEAT_TICKS(RT), .REPEAT_EN(0)
  ) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: held[i] = ticks seen since the press was reported (-1 when idle).
  int            cyc;
  bit            m_s1 [NK];
  bit            m_s2 [NK];
  int            run  [NK];
  bit            lvl  [NK];
  bit            lvl_d[NK];
  int            held [NK];
  logic [NK-1:0] e_level, e_press, e_release, e_long, e_rep_a;

  task automatic model_reset();
    cyc = 0;
    for (int i = 0; i < NK; i++) begin
      m_s1[i] = 1'b1; m_s2[i] = 1'b1; run[i] = 0;
      lvl[i] = 1'b0; lvl_d[i] = 1'b0; held[i] = -1;
    end
    e_level = '0; e_press = '0; e_release = '0; e_long = '0; e_rep_a = '0;
  endtask

  task automatic model_step();
    bit tk;
    bit raw, pre_lvl, pre_d;
    tk = (cyc % TD) == (TD - 1);
    cyc++;
    for (int i = 0; i < NK; i++) begin
      raw = !m_s2[i];
      pre_lvl = lvl[i];
      pre_d = lvl_d[i];
      e_press[i]   = pre_lvl && !pre_d;
      e_release[i] = !pre_lvl && pre_d;
      e_long[i]    = 1'b0;
      e_rep_a[i]   = 1'b0;
      if (e_release[i]) held[i] = -1;
      else if (e_press[i]) held[i] = 0;
      else if (held[i] >= 0 && tk) begin
        held[i]++;
        e_long[i]  = (held[i] == LT);
        e_rep_a[i] = (held[i] > LT) && (((held[i] - LT) % RT) == 0);
      end
      lvl_d[i] = pre_lvl;
      if (tk) begin
        if (raw != pre_lvl) begin
          run[i]++;
          if (run[i] == SC) begin
            lvl[i] = !lvl[i];
            run[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
      e_level[i] = lvl[i];
      m_s2[i] = m_s1[i];
      m_s1[i] = keys[i];
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  int            cnt_press[NK], cnt_release[NK], cnt_long[NK], cnt_rep_a[NK], cnt_rep_b[NK];
  int            all3_press = 0, all3_release = 0, press_wide = 0;
  logic [NK-1:0] prev_press = '0;

  initial begin
    for (int i = 0; i < NK; i++) begin
      cnt_press[i] = 0; cnt_release[i] = 0; cnt_long[i] = 0; cnt_rep_a[i] = 0; cnt_rep_b[i] = 0;
    end
    forever begin
      @(negedge clk);
      chk("key_level",       32'(bus_a.key_level),     32'(e_level));
      chk("press_pulse",     32'(bus_a.press_pulse),   32'(e_press));
      chk("release_pulse",   32'(bus_a.release_pulse), 32'(e_release));
      chk("long_pulse",      32'(bus_a.long_pulse),    32'(e_long));
      chk("repeat_pulse",    32'(bus_a.repeat_pulse),  32'(e_rep_a));
      chk("norep_key_level", 32'(bus_b.key_level),     32'(e_level));
      chk("norep_long",      32'(bus_b.long_pulse),    32'(e_long));
      chk("norep_repeat",    32'(bus_b.repeat_pulse),  32'(0));
      for (int i = 0; i < NK; i++) begin
        cnt_press[i]   += int'(bus_a.press_pulse[i]);
        cnt_release[i] += int'(bus_a.release_pulse[i]);
        cnt_long[i]    += int'(bus_a.long_pulse[i]);
        cnt_rep_a[i]   += int'(bus_a.repeat_pulse[i]);
        cnt_rep_b[i]   += int'(bus_b.repeat_pulse[i]);
      end
      if (bus_a.press_pulse == '1) all3_press++;
      if (bus_a.release_pulse == '1) all3_release++;
      if ((bus_a.press_pulse & prev_press) != '0) press_wide++;
      prev_press = bus_a.press_pulse;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  int b_press, b_release, b_long, b_rep_a, b_rep_b, b_all_p, b_all_r;

  initial begin
    int k;
    step(4);
    chk("reset_level", 32'(bus_a.key_level), 32'(0));
    chk("reset_pulses", 32'(bus_a.press_pulse | bus_a.release_pulse | bus_a.long_pulse), 32'(0));
    rst = 1'b0;
    step(3);

    // Long hold on key 0
    b_press = cnt_press[0]; b_release = cnt_release[0]; b_long = cnt_long[0];
    keys[0] = 1'b0;
    step(40 * TD);
    chk("hold0_level", 32'(bus_a.key_level[0]), 32'(1));
    keys[0] = 1'b1;
    step(10 * TD);
    chk("hold0_press_cnt",   32'(cnt_press[0] - b_press),     32'(1));
    chk("hold0_release_cnt", 32'(cnt_release[0] - b_release), 32'(1));
    chk("hold0_long_cnt",    32'(cnt_long[0] - b_long),       32'(1));

    // Short bounce on key 1: two ticks low is not enough
    b_press = cnt_press[1]; b_release = cnt_release[1];
    keys[1] = 1'b0;
    step(2 * TD);
    keys[1] = 1'b1;
    step(10 * TD);
    chk("bounce1_press_cnt",   32'(cnt_press[1] - b_press),     32'(0));
    chk("bounce1_release_cnt", 32'(cnt_release[1] - b_release), 32'(0));
    chk("bounce1_level",       32'(bus_a.key_level[1]),         32'(0));

    // Auto-repeat on key 2, with and without repeat enabled
    b_press = cnt_press[2]; b_long = cnt_long[2]; b_rep_a = cnt_rep_a[2]; b_rep_b = cnt_rep_b[2];
    keys[2] = 1'b0;
    step(20 * TD);
    keys[2] = 1'b1;
    step(10 * TD);
    chk("rep2_press_cnt",  32'(cnt_press[2] - b_press), 32'(1));
    chk("rep2_long_cnt",   32'(cnt_long[2] - b_long),   32'(1));
    chk("rep2_has_repeat", 32'((cnt_rep_a[2] - b_rep_a) >= 4), 32'(1));
    chk("norep2_rep_cnt",  32'(cnt_rep_b[2] - b_rep_b), 32'(0));

    // All keys together
    b_all_p = all3_press; b_all_r = all3_release;
    keys = '0;
    step(15 * TD);
    keys = '1;
    step(12 * TD);
    chk("all3_press_same_cycle",   32'(all3_press - b_all_p),   32'(1));
    chk("all3_release_same_cycle", 32'(all3_release - b_all_r), 32'(1));

    // Reset while key 0 is held and accepted
    keys[0] = 1'b0;
    k = 0;
    while (k < 10 * TD && !bus_a.key_level[0]) begin
      step(1);
      k++;
    end
    chk("pre_rst_level0", 32'(bus_a.key_level[0]), 32'(1));
    step(3);
    b_release = cnt_release[0];
    rst = 1'b1;
    #1;
    chk("rst_level_now",  32'(bus_a.key_level), 32'(0));
    chk("rst_pulses_now", 32'(bus_a.press_pulse | bus_a.release_pulse | bus_a.long_pulse | bus_a.repeat_pulse), 32'(0));
    step(3);
    rst = 1'b0;
    b_press = cnt_press[0];
    k = 0;
    while (k < 20 * TD && cnt_press[0] == b_press) begin
      step(1);
      k++;
    end
    chk("post_rst_press0",     32'(cnt_press[0] - b_press),     32'(1));
    chk("post_rst_no_release", 32'(cnt_release[0] - b_release), 32'(0));
    keys[0] = 1'b1;
    step(10 * TD);

    // Random bouncing keys
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NK; i++)
        if ($urandom_range(0, 24) == 0) keys[i] = ~keys[i];
      step(1);
    end
    keys = '1;
    step(20 * TD);

    chk("press_width_one", 32'(press_wide), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
